// File: rtl/rtc_bus_slave.sv
// Behavioural stand-in for the external RTC chip on the multiplexed CS/AD/WR/RD bus.
// Holds control, BCD time and date registers and runs its own BCD seconds clock.
module rtc_bus_slave #(
  parameter int TICK_DIV = 100,
  parameter int TW       = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          CS,
  input  logic          AD,
  input  logic          WR,
  input  logic          RD,
  inout  wire  [TW-1:0] RTC_BUS,
  output logic [TW-1:0] seg_out,
  output logic          tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] div_reg;
  logic          wr_q_reg;
  logic          tick_reg;
  logic          tick_pending_reg;
  logic          oe_reg;
  logic [TW-1:0] rdata_reg;
  logic [TW-1:0] addr_reg;
  logic [TW-1:0] hold_reg;
  logic [TW-1:0] ctrl_reg, sec_reg, min_reg, hour_reg;
  logic [TW-1:0] day_reg, month_reg, year_reg;

  logic          addr_phase, data_phase, commit, rd_active;
  logic          wrap, halt, do_inc;
  logic          sec_wrap, min_wrap;
  logic [DW-1:0] div_next;
  logic [TW-1:0] sec_next, min_next, hour_next;
  logic [TW-1:0] rd_mux;

  // Out-of-range values are only corrected once they reach the rollover limit.
  function automatic logic [TW-1:0] bcd_inc(input logic [TW-1:0] v, input logic [TW-1:0] lim);
    if (v >= lim)
      return '0;
    else if (v[3:0] >= 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    else
      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  assign addr_phase = !CS && !AD && !WR;
  assign data_phase = !CS &&  AD && !WR;
  assign commit     = !CS &&  AD && !wr_q_reg && WR;
  assign rd_active  = !CS &&  AD && !RD && WR;

  assign halt     = ctrl_reg[0];
  assign wrap     = (div_reg == DW'(TICK_DIV - 1));
  assign div_next = wrap ? '0 : div_reg + 1'b1;
  // A wrap that lands on a write commit is deferred one cycle so it sees the new values.
  assign do_inc   = tick_pending_reg || (wrap && !halt && !commit);

  assign sec_wrap  = (sec_reg >= 8'h59);
  assign min_wrap  = (min_reg >= 8'h59);
  assign sec_next  = bcd_inc(sec_reg,  8'h59);
  assign min_next  = bcd_inc(min_reg,  8'h59);
  assign hour_next = bcd_inc(hour_reg, 8'h23);

  always_comb begin
    rd_mux = '0;
    case (addr_reg)
      8'h00:   rd_mux = ctrl_reg;
      8'h21:   rd_mux = sec_reg;
      8'h22:   rd_mux = min_reg;
      8'h23:   rd_mux = hour_reg;
      8'h24:   rd_mux = day_reg;
      8'h25:   rd_mux = month_reg;
      8'h26:   rd_mux = year_reg;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_reg          <= '0;
      wr_q_reg         <= 1'b1;
      tick_reg         <= 1'b0;
      tick_pending_reg <= 1'b0;
      oe_reg           <= 1'b0;
      rdata_reg        <= '0;
      addr_reg         <= '0;
      hold_reg         <= '0;
      ctrl_reg         <= '0;
      sec_reg          <= '0;
      min_reg          <= '0;
      hour_reg         <= '0;
      day_reg          <= '0;
      month_reg        <= '0;
      year_reg         <= '0;
    end else begin
      div_reg          <= div_next;
      wr_q_reg         <= WR;
      tick_reg         <= do_inc;
      tick_pending_reg <= wrap && !halt && commit;
      oe_reg           <= rd_active;
      if (rd_active)  rdata_reg <= rd_mux;
      if (addr_phase) addr_reg  <= RTC_BUS;
      if (data_phase) hold_reg  <= RTC_BUS;
      if (commit) begin
        case (addr_reg)
          8'h00:   ctrl_reg  <= hold_reg;
          8'h21:   sec_reg   <= hold_reg;
          8'h22:   min_reg   <= hold_reg;
          8'h23:   hour_reg  <= hold_reg;
          8'h24:   day_reg   <= hold_reg;
          8'h25:   month_reg <= hold_reg;
          8'h26:   year_reg  <= hold_reg;
          default: ;
        endcase
      end
      if (do_inc) begin
        sec_reg <= sec_next;
        if (sec_wrap) begin
          min_reg <= min_next;
          if (min_wrap) hour_reg <= hour_next;
        end
      end
    end
  end

  assign RTC_BUS = oe_reg ? rdata_reg : 'z;
  assign seg_out = sec_reg;
  assign tick    = tick_reg;

endmodule
